// File: rtl/constraint_search_sched_pkg.sv
// Shared types and helpers for the constraint-search sequencer.
// Holds the FSM encoding, the LFSR feedback taps and the scoring helpers.
package cosmos_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_WAIT,
    S_EVAL,
    S_REPORT
  } state_t;

  localparam logic [63:0] LFSR64_TAPS = 64'hD800_0000_0000_0000;

  // Widest per-constraint vector the popcount helper accepts.
  localparam int POP_MAX = 256;

  function automatic int score_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [8:0] popcount(input logic [POP_MAX-1:0] v);
    logic [8:0] c;
    c = '0;
    for (int i = 0; i < POP_MAX; i++) begin
      c = c + 9'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/constraint_search_sched_lfsr64.sv
// 64-bit right-shifting Galois LFSR; nxt is the value the register takes at the coming edge.
// A zero seed is replaced by 1 so the generator never locks up.
module lfsr64_galois
  import cosmos_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [63:0] seed,
  output logic [63:0] nxt
);

  logic [63:0] q;

  always_comb begin
    nxt = q;
    if (load) begin
      nxt = (seed == 64'd0) ? 64'd1 : seed;
    end else if (step) begin
      nxt = (q >> 1) ^ (q[0] ? LFSR64_TAPS : 64'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 64'd1;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/constraint_search_sched.sv
// Drives a combinational constraint checker with LFSR candidates, one try every CHECK_LAT+2 cycles,
// keeps the best partial candidate and holds the result on a valid/ready port until consumed.
module constraint_search_sched
  import cosmos_sched_pkg::*;
#(
  parameter int CAND_W    = 64,
  parameter int N_CONS    = 32,
  parameter int CHECK_LAT = 1,
  parameter int TRY_W     = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic [CAND_W-1:0]           seed,
  input  logic [TRY_W-1:0]            max_tries,
  output logic [CAND_W-1:0]           cand_out,
  output logic                        cand_valid,
  input  logic                        chk_x,
  input  logic [N_CONS-1:0]           chk_vec,
  output logic                        busy,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic                        res_found,
  output logic [CAND_W-1:0]           res_cand,
  output logic [score_w(N_CONS)-1:0]  res_score,
  output logic [TRY_W-1:0]            res_tries
);

  localparam int SCORE_W = score_w(N_CONS);
  localparam int WAIT_W  = (CHECK_LAT > 1) ? $clog2(CHECK_LAT + 1) : 1;
  localparam logic [SCORE_W-1:0] FULL_SCORE = SCORE_W'(N_CONS);
  localparam logic [WAIT_W-1:0]  WAIT_INIT  = WAIT_W'(CHECK_LAT);

  state_t state, state_nxt;

  logic [WAIT_W-1:0]  wait_cnt;
  logic [TRY_W-1:0]   tries, tries_inc;
  logic [SCORE_W-1:0] best_score, cur_score, upd_score;
  logic [CAND_W-1:0]  best_cand, upd_cand, lfsr_d;
  logic               go, eval, better, hit_limit, lfsr_step;

  assign go        = (state == S_IDLE) && start && !abort;
  assign eval      = (state == S_EVAL) && !abort;
  assign tries_inc = (&tries) ? tries : tries + 1'b1;
  assign cur_score = SCORE_W'(popcount(POP_MAX'(chk_vec)));
  // Ties keep the earlier candidate.
  assign better    = cur_score > best_score;
  assign upd_score = better ? cur_score : best_score;
  assign upd_cand  = better ? cand_out : best_cand;
  assign hit_limit = (max_tries != '0) && (tries_inc == max_tries);
  assign lfsr_step = eval && !chk_x && !hit_limit;

  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_REPORT);

  lfsr64_galois u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (go),
    .step (lfsr_step),
    .seed (seed),
    .nxt  (lfsr_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_APPLY;
      S_APPLY:  state_nxt = (CHECK_LAT > 0) ? S_WAIT : S_EVAL;
      S_WAIT:   if (wait_cnt <= WAIT_W'(1)) state_nxt = S_EVAL;
      S_EVAL:   state_nxt = (chk_x || hit_limit) ? S_REPORT : S_APPLY;
      S_REPORT: if (res_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (abort) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cand_out   <= '0;
      cand_valid <= 1'b0;
      wait_cnt   <= '0;
      tries      <= '0;
      best_score <= '0;
      best_cand  <= '0;
      res_found  <= 1'b0;
      res_cand   <= '0;
      res_score  <= '0;
      res_tries  <= '0;
    end else begin
      // cand_out is loaded on entry to APPLY so it is already valid during the APPLY cycle.
      cand_valid <= (state_nxt == S_APPLY);
      if (state_nxt == S_APPLY) cand_out <= lfsr_d;

      if (state == S_APPLY) begin
        wait_cnt <= WAIT_INIT;
      end else if (state == S_WAIT) begin
        wait_cnt <= wait_cnt - 1'b1;
      end

      if (go) begin
        tries      <= '0;
        best_score <= '0;
        best_cand  <= '0;
      end else if (eval) begin
        tries      <= tries_inc;
        best_score <= upd_score;
        best_cand  <= upd_cand;
        if (chk_x) begin
          res_found <= 1'b1;
          res_cand  <= cand_out;
          res_score <= FULL_SCORE;
          res_tries <= tries_inc;
        end else if (hit_limit) begin
          res_found <= 1'b0;
          res_cand  <= upd_cand;
          res_score <= upd_score;
          res_tries <= tries_inc;
        end
      end

      if (abort) begin
        res_found <= 1'b0;
        res_cand  <= '0;
        res_score <= '0;
        res_tries <= '0;
      end
    end
  end

endmodule

// File: tb/tb_constraint_search_sched.sv
// Directed bench: two sequencers (CHECK_LAT=1 and 0) each driving a small checker stub.
module tb_constraint_search_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        start [2];
  logic        abort;
  logic [63:0] seed;
  logic [31:0] max_tries;
  logic        res_ready;

  logic [63:0] cand_out   [2];
  logic        cand_valid [2];
  logic        chk_x      [2];
  logic [31:0] chk_vec    [2];
  logic        busy       [2];
  logic        res_valid  [2];
  logic        res_found  [2];
  logic [63:0] res_cand   [2];
  logic [5:0]  res_score  [2];
  logic [31:0] res_tries  [2];

  int          mode;
  logic [63:0] target;
  logic [32:0] s0, s1;

  // mode 0: always solved, mode 1: never, mode 2: 3/7/7 bits, mode 3: solved at target.
  function automatic logic [32:0] stub(input int m, input logic [63:0] c, input logic [63:0] tgt);
    logic [32:0] r;
    r = {1'b0, 32'h0};
    case (m)
      0: r = {1'b1, 32'h0};
      1: r = {1'b0, 32'h0};
      2: begin
        if (c == 64'h1) r = {1'b0, 32'h7};
        else if (c == 64'hD800_0000_0000_0000) r = {1'b0, 32'h7F};
        else r = {1'b0, 32'hFE};
      end
      default: r = {(c == tgt), 32'h1};
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) s0 <= stub(mode, cand_out[0], target);
  assign s1 = stub(mode, cand_out[1], target);
  assign chk_x[0]   = s0[32];
  assign chk_vec[0] = s0[31:0];
  assign chk_x[1]   = s1[32];
  assign chk_vec[1] = s1[31:0];

  constraint_search_sched #(.CAND_W(64), .N_CONS(32), .CHECK_LAT(1), .TRY_W(32)) dut_l1 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort), .seed(seed), .max_tries(max_tries),
    .cand_out(cand_out[0]), .cand_valid(cand_valid[0]), .chk_x(chk_x[0]), .chk_vec(chk_vec[0]),
    .busy(busy[0]), .res_valid(res_valid[0]), .res_ready(res_ready), .res_found(res_found[0]),
    .res_cand(res_cand[0]), .res_score(res_score[0]), .res_tries(res_tries[0])
  );

  constraint_search_sched #(.CAND_W(64), .N_CONS(32), .CHECK_LAT(0), .TRY_W(32)) dut_l0 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort), .seed(seed), .max_tries(max_tries),
    .cand_out(cand_out[1]), .cand_valid(cand_valid[1]), .chk_x(chk_x[1]), .chk_vec(chk_vec[1]),
    .busy(busy[1]), .res_valid(res_valid[1]), .res_ready(res_ready), .res_found(res_found[1]),
    .res_cand(res_cand[1]), .res_score(res_score[1]), .res_tries(res_tries[1])
  );

  int total = 0;
  int bad   = 0;
  logic [63:0] cand_log [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Runs one search; cyc counts cycles from the APPLY cycle (1) to the first res_valid cycle.
  task automatic run_search(input int sel, input logic [63:0] sd, input logic [31:0] mt,
                            input int hold, output logic ok, output logic f,
                            output logic [63:0] c, output logic [5:0] sc,
                            output logic [31:0] tr, output int cyc, output int unstable);
    cand_log.delete();
    ok = 1'b0; f = 1'b0; c = '0; sc = '0; tr = '0; cyc = 0; unstable = 0;
    @(negedge clk);
    seed = sd; max_tries = mt; start[sel] = 1'b1;
    @(negedge clk);
    start[sel] = 1'b0;
    cyc = 1;
    for (int i = 0; i < 300; i++) begin
      if (cand_valid[sel]) cand_log.push_back(cand_out[sel]);
      if (res_valid[sel]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    if (!ok) begin
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      return;
    end
    f = res_found[sel]; c = res_cand[sel]; sc = res_score[sel]; tr = res_tries[sel];
    repeat (hold) begin
      @(negedge clk);
      if (!res_valid[sel] || res_found[sel] !== f || res_cand[sel] !== c ||
          res_score[sel] !== sc || res_tries[sel] !== tr) unstable++;
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  typedef struct {
    int          sel;
    int          mode;
    logic [63:0] seed;
    logic [31:0] mt;
    int          hold;
    logic        found;
    logic [63:0] cand;
    logic [5:0]  score;
    logic [31:0] tries;
    int          cyc;
  } vec_t;

  vec_t vt [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        ok, f;
    logic [63:0] c;
    logic [5:0]  sc;
    logic [31:0] tr;
    int          cyc, unstable, busy_cnt;
    logic [63:0] exp_seq [3];

    start[0] = 1'b0; start[1] = 1'b0; abort = 1'b0; seed = '0; max_tries = '0;
    res_ready = 1'b0; mode = 0; target = 64'h3B80_0000_0000_0000;
    exp_seq[0] = 64'h1; exp_seq[1] = 64'hD800_0000_0000_0000; exp_seq[2] = 64'h6C00_0000_0000_0000;

    //            sel mode seed     max    hold found cand                    score  tries  cyc
    vt[0] = '{0, 0, 64'd5, 32'd0, 2,  1'b1, 64'd5,                  6'd32, 32'd1, 4};
    vt[1] = '{0, 1, 64'd1, 32'd3, 10, 1'b0, 64'd0,                  6'd0,  32'd3, 10};
    vt[2] = '{0, 2, 64'd1, 32'd3, 2,  1'b0, 64'hD800_0000_0000_0000, 6'd7,  32'd3, 10};
    vt[3] = '{0, 3, 64'd5, 32'd0, 1,  1'b1, 64'h3B80_0000_0000_0000, 6'd32, 32'd6, 19};
    vt[4] = '{1, 3, 64'd5, 32'd0, 1,  1'b1, 64'h3B80_0000_0000_0000, 6'd32, 32'd6, 13};
    vt[5] = '{1, 0, 64'd0, 32'd0, 0,  1'b1, 64'd1,                  6'd32, 32'd1, 3};
    vt[6] = '{0, 2, 64'd1, 32'd1, 3,  1'b0, 64'd1,                  6'd3,  32'd1, 4};
    vt[7] = '{1, 1, 64'd1, 32'd2, 0,  1'b0, 64'd0,                  6'd0,  32'd2, 5};

    repeat (2) @(negedge clk);
    check("rst cand_out",   cand_out[0], 64'd0);
    check("rst cand_valid", 64'(cand_valid[0]), 64'd0);
    check("rst busy",       64'(busy[0]), 64'd0);
    check("rst res_valid",  64'(res_valid[0]), 64'd0);
    check("rst res_found",  64'(res_found[0]), 64'd0);
    check("rst res_cand",   res_cand[0], 64'd0);
    check("rst res_score",  64'(res_score[0]), 64'd0);
    check("rst res_tries",  64'(res_tries[0]), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy l0",   64'(busy[1]), 64'd0);
    check("idle cand l0",   cand_out[1], 64'd0);

    for (int i = 0; i < 8; i++) begin
      mode = vt[i].mode;
      run_search(vt[i].sel, vt[i].seed, vt[i].mt, vt[i].hold, ok, f, c, sc, tr, cyc, unstable);
      check($sformatf("v%0d result seen", i), 64'(ok), 64'd1);
      check($sformatf("v%0d found", i), 64'(f), 64'(vt[i].found));
      check($sformatf("v%0d cand", i), c, vt[i].cand);
      check($sformatf("v%0d score", i), 64'(sc), 64'(vt[i].score));
      check($sformatf("v%0d tries", i), 64'(tr), 64'(vt[i].tries));
      check($sformatf("v%0d latency", i), 64'(cyc), 64'(vt[i].cyc));
      check($sformatf("v%0d cand pulses", i), 64'(cand_log.size()), 64'(vt[i].tries));
      check($sformatf("v%0d stable", i), 64'(unstable), 64'd0);
      check($sformatf("v%0d valid drop", i), 64'(res_valid[vt[i].sel]), 64'd0);
      check($sformatf("v%0d busy drop", i), 64'(busy[vt[i].sel]), 64'd0);
    end

    // LFSR sequence seen on cand_out from seed 1.
    mode = 1;
    run_search(0, 64'd1, 32'd3, 0, ok, f, c, sc, tr, cyc, unstable);
    check("seq count", 64'(cand_log.size()), 64'd3);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("seq cand%0d", k),
            (k < cand_log.size()) ? cand_log[k] : 64'hFFFF_FFFF_FFFF_FFFF, exp_seq[k]);
    end

    // Abort in the second WAIT cycle; a stray start mid-search is ignored.
    mode = 1;
    @(negedge clk);
    seed = 64'd3; max_tries = 32'd0; start[0] = 1'b1;
    @(negedge clk);                       // APPLY
    start[0] = 1'b0;
    @(negedge clk);                       // WAIT
    start[0] = 1'b1;
    @(negedge clk);                       // EVAL
    start[0] = 1'b0;
    @(negedge clk);                       // APPLY, second candidate
    check("midrun start ignored cv", 64'(cand_valid[0]), 64'd1);
    check("midrun start ignored c",  cand_out[0], 64'hD800_0000_0000_0001);
    @(negedge clk);                       // second WAIT
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort busy", 64'(busy[0]), 64'd0);
    check("abort cand held", cand_out[0], 64'hD800_0000_0000_0001);
    busy_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (res_valid[0] || busy[0] || cand_valid[0]) busy_cnt++;
    end
    check("abort quiet", 64'(busy_cnt), 64'd0);

    // Abort and start together in IDLE: abort wins.
    abort = 1'b1; start[0] = 1'b1;
    @(negedge clk);
    abort = 1'b0; start[0] = 1'b0;
    check("abort+start busy", 64'(busy[0]), 64'd0);
    check("abort+start cv", 64'(cand_valid[0]), 64'd0);

    mode = 0;
    run_search(0, 64'd9, 32'd0, 0, ok, f, c, sc, tr, cyc, unstable);
    check("restart seen",  64'(ok), 64'd1);
    check("restart tries", 64'(tr), 64'd1);
    check("restart cand",  c, 64'd9);
    check("restart found", 64'(f), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
